// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate response checker.
package gate_chk_pkg;

    // Checker run states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_SETTLE  = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    // Truth tables indexed by {a,b}: bit i is the expected y for {a,b}==i
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

    // Coverage value meaning every input vector has been compared
    localparam logic [3:0] COV_ALL = 4'b1111;

    // One-hot coverage bit for a captured vector index
    function automatic logic [3:0] idx_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    localparam logic [W-1:0] MAX_VAL = '1;

    logic [W-1:0] r_count;

    // Clear has priority over increment; increment stops at the maximum value
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX_VAL)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/gate_response_checker.sv
// Observes a 2-input gate under test: captures each applied vector, waits a
// settle time, samples y and compares it with a truth table. Tracks pass/fail
// counts, vector coverage, the first mismatch and stimulus overruns.
module gate_response_checker
    import gate_chk_pkg::*;
#(
    parameter logic [3:0] TRUTH  = TT_AND,
    parameter int         SETTLE = 2,
    parameter int         CNT_W  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_vec_valid,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_y,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [CNT_W-1:0] o_pass_count,
    output logic [CNT_W-1:0] o_fail_count,
    output logic [3:0]       o_coverage,
    output logic [2:0]       o_first_fail,
    output logic             o_overrun
);

    // Settle count at which the FSM moves on to COMPARE
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [1:0]       r_idx;
    logic [3:0]       r_cnt;
    logic [3:0]       r_cov;
    logic [2:0]       r_first_fail;
    logic             r_overrun;

    logic             w_capture;
    logic             w_compare;
    logic             w_ovr_set;
    logic             w_match;
    logic             w_first;
    logic [3:0]       w_cov_upd;
    logic [CNT_W-1:0] w_pass_count;
    logic [CNT_W-1:0] w_fail_count;

    assign w_cov_upd = r_cov | idx_onehot(r_idx);
    assign w_match   = (i_y == TRUTH[r_idx]);
    // Only the mismatch that takes the fail count off zero records first_fail
    assign w_first   = w_compare && !w_match && (w_fail_count == '0);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and per-cycle control strobes; start overrides everything
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_compare    = 1'b0;
        w_ovr_set    = 1'b0;
        if (i_start) begin
            w_state_next = S_WAIT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_next = S_IDLE;
                end
                S_WAIT: begin
                    if (i_vec_valid) begin
                        w_capture    = 1'b1;
                        w_state_next = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    w_ovr_set = i_vec_valid;
                    if (r_cnt == SETTLE_LAST) begin
                        w_state_next = S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    w_ovr_set    = i_vec_valid;
                    w_compare    = 1'b1;
                    w_state_next = (w_cov_upd == COV_ALL) ? S_DONE : S_WAIT;
                end
                S_DONE: begin
                    w_state_next = S_DONE;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // Vector capture and settle counter; counter restarts on every capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx <= 2'b00;
            r_cnt <= 4'd0;
        end else if (w_capture) begin
            r_idx <= {i_a, i_b};
            r_cnt <= 4'd0;
        end else if (r_state == S_SETTLE) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // Result bookkeeping: coverage, first mismatch and sticky overrun
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cov        <= 4'b0000;
            r_first_fail <= 3'b000;
            r_overrun    <= 1'b0;
        end else if (i_start) begin
            r_cov        <= 4'b0000;
            r_first_fail <= 3'b000;
            r_overrun    <= 1'b0;
        end else begin
            if (w_compare) begin
                r_cov <= w_cov_upd;
            end
            if (w_first) begin
                r_first_fail <= {r_idx, i_y};
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_pass_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_start),
        .i_inc   (w_compare && w_match),
        .o_count (w_pass_count)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_fail_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_start),
        .i_inc   (w_compare && !w_match),
        .o_count (w_fail_count)
    );

    assign o_busy       = (r_state == S_WAIT) || (r_state == S_SETTLE) || (r_state == S_COMPARE);
    assign o_done       = (r_state == S_DONE);
    // Saturation does not matter here: a saturated fail count is still non-zero
    assign o_pass       = o_done && (w_fail_count == '0) && !r_overrun;
    assign o_pass_count = w_pass_count;
    assign o_fail_count = w_fail_count;
    assign o_coverage   = r_cov;
    assign o_first_fail = r_first_fail;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench for gate_response_checker: stimulus pushes expected output
// snapshots (with the cycle they become visible) into a queue; a negedge
// monitor pops them and compares the DUT outputs every cycle.
module tb_gate_response_checker;
    import gate_chk_pkg::*;

    localparam int S     = 2;
    localparam int W     = 3;
    localparam int MAXC  = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         vec_valid;
    logic         a;
    logic         b;
    logic         y;
    logic         stuck;
    logic         err;
    logic         busy;
    logic         done;
    logic         pass;
    logic [W-1:0] pass_count;
    logic [W-1:0] fail_count;
    logic [3:0]   coverage;
    logic [2:0]   first_fail;
    logic         overrun;

    // The gate under test: an AND gate with optional stuck-at-0 or injected error
    assign y = stuck ? 1'b0 : ((a & b) ^ err);

    gate_response_checker #(
        .TRUTH  (TT_AND),
        .SETTLE (S),
        .CNT_W  (W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_vec_valid  (vec_valid),
        .i_a          (a),
        .i_b          (b),
        .i_y          (y),
        .o_busy       (busy),
        .o_done       (done),
        .o_pass       (pass),
        .o_pass_count (pass_count),
        .o_fail_count (fail_count),
        .o_coverage   (coverage),
        .o_first_fail (first_fail),
        .o_overrun    (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int           due;
        logic         busy;
        logic         done;
        logic [W-1:0] pc;
        logic [W-1:0] fc;
        logic [3:0]   cov;
        logic [2:0]   ff;
        logic         ovr;
    } exp_t;

    exp_t q[$];
    exp_t cur = '0;

    int checks = 0;
    int errors = 0;

    // Reference model state (transaction level)
    bit       running   = 1'b0;
    bit       mdone     = 1'b0;
    bit       movr      = 1'b0;
    int       mpc       = 0;
    int       mfc       = 0;
    logic [3:0] mcov    = 4'b0000;
    logic [2:0] mff     = 3'b000;
    int       busy_until = -1;
    exp_t     pre_pending = '0;

    logic [16:0] dut_pk;
    assign dut_pk = {busy, done, pass, pass_count, fail_count, coverage, first_fail, overrun};

    function automatic logic [16:0] pk(input exp_t e);
        logic p;
        p = e.done && (e.fc == '0) && !e.ovr;
        return {e.busy, e.done, p, e.pc, e.fc, e.cov, e.ff, e.ovr};
    endfunction

    function automatic exp_t snap(input int due);
        exp_t e;
        e.due  = due;
        e.busy = running && !mdone;
        e.done = mdone;
        e.pc   = mpc[W-1:0];
        e.fc   = mfc[W-1:0];
        e.cov  = mcov;
        e.ff   = mff;
        e.ovr  = movr;
        return e;
    endfunction

    function automatic void push_sorted(input exp_t e);
        int i = 0;
        while (i < q.size() && q[i].due <= e.due) i++;
        q.insert(i, e);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Monitor: apply every expectation that has become due, then compare
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) cur = q.pop_front();
        check("outputs", 32'(dut_pk), 32'(pk(cur)));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit with_vec);
        int k = cyc;
        start     = 1'b1;
        vec_valid = with_vec;
        a         = 1'($urandom_range(0, 1));
        b         = 1'($urandom_range(0, 1));
        err       = 1'b0;
        while (q.size() > 0 && q[q.size()-1].due >= k + 1) void'(q.pop_back());
        running    = 1'b1;
        mdone      = 1'b0;
        movr       = 1'b0;
        mpc        = 0;
        mfc        = 0;
        mcov       = 4'b0000;
        mff        = 3'b000;
        busy_until = -1;
        push_sorted(snap(k + 1));
        $display("cyc=%0d start vec=%0b", k, with_vec);
        tick(1);
        start     = 1'b0;
        vec_valid = 1'b0;
    endtask

    task automatic do_vec(input logic na, input logic nb, input logic ne);
        int   k = cyc;
        bit   pending = running && (k <= busy_until);
        logic yv;
        exp_t e;
        if (!pending) begin
            a   = na;
            b   = nb;
            err = ne;
        end
        vec_valid = 1'b1;
        if (pending) begin
            movr = 1'b1;
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].due >= k + 1) q[i].ovr = 1'b1;
            end
            pre_pending.ovr = 1'b1;
            if (k < busy_until) begin
                e     = pre_pending;
                e.due = k + 1;
                push_sorted(e);
            end
            $display("cyc=%0d vec overrun", k);
        end else if (running && !mdone) begin
            pre_pending = snap(0);
            yv = stuck ? 1'b0 : ((na & nb) ^ ne);
            if (yv == (na & nb)) begin
                if (mpc < MAXC) mpc++;
            end else begin
                if (mfc == 0) mff = {na, nb, yv};
                if (mfc < MAXC) mfc++;
            end
            mcov[{na, nb}] = 1'b1;
            mdone      = (mcov == 4'b1111);
            busy_until = k + S + 1;
            push_sorted(snap(k + S + 2));
            $display("cyc=%0d vec ab=%0b%0b y=%0b", k, na, nb, yv);
        end else begin
            $display("cyc=%0d vec ignored ab=%0b%0b", k, na, nb);
        end
        tick(1);
        vec_valid = 1'b0;
    endtask

    task automatic do_reset();
        int k = cyc;
        start     = 1'b0;
        vec_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("async_reset", 32'(dut_pk), 32'd0);
        running    = 1'b0;
        mdone      = 1'b0;
        movr       = 1'b0;
        mpc        = 0;
        mfc        = 0;
        mcov       = 4'b0000;
        mff        = 3'b000;
        busy_until = -1;
        q.delete();
        push_sorted(snap(k));
        $display("cyc=%0d reset", k);
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic vec_spaced(input logic na, input logic nb);
        do_vec(na, nb, 1'b0);
        tick(4);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        vec_valid = 1'b0;
        a         = 1'b0;
        b         = 1'b0;
        stuck     = 1'b0;
        err       = 1'b0;
        push_sorted(snap(0));
        tick(3);
        check("reset_pass_count", 32'(pass_count), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Vector while idle is ignored
        do_vec(1'b1, 1'b1, 1'b0);
        tick(5);
        check("idle_ignored_cov", 32'(coverage), 32'd0);

        // 1: good AND gate, all four vectors
        do_start(1'b0);
        vec_spaced(0, 0); vec_spaced(0, 1); vec_spaced(1, 0); vec_spaced(1, 1);
        tick(2);
        check("t1_pass_count", 32'(pass_count), 32'd4);
        check("t1_fail_count", 32'(fail_count), 32'd0);
        check("t1_coverage", 32'(coverage), 32'hF);
        check("t1_done", 32'(done), 32'd1);
        check("t1_pass", 32'(pass), 32'd1);

        // 2: gate stuck at 0
        stuck = 1'b1;
        do_start(1'b0);
        vec_spaced(0, 0); vec_spaced(0, 1); vec_spaced(1, 0); vec_spaced(1, 1);
        tick(2);
        stuck = 1'b0;
        check("t2_pass_count", 32'(pass_count), 32'd3);
        check("t2_fail_count", 32'(fail_count), 32'd1);
        check("t2_first_fail", 32'(first_fail), 32'b110);
        check("t2_pass", 32'(pass), 32'd0);
        check("t2_done", 32'(done), 32'd1);

        // 3: second vec_valid one cycle after the first
        do_start(1'b0);
        do_vec(1'b1, 1'b1, 1'b0);
        do_vec(1'b1, 1'b1, 1'b0);
        tick(6);
        check("t3_overrun", 32'(overrun), 32'd1);
        check("t3_pass_count", 32'(pass_count), 32'd1);

        // 4: partial coverage
        do_start(1'b0);
        vec_spaced(0, 0); vec_spaced(0, 1); vec_spaced(1, 0);
        check("t4_coverage", 32'(coverage), 32'b0111);
        check("t4_busy", 32'(busy), 32'd1);
        check("t4_done", 32'(done), 32'd0);

        // 5: counter saturation on a repeated vector
        do_start(1'b0);
        repeat (MAXC + 2) vec_spaced(1, 1);
        check("t5_saturate", 32'(pass_count), 32'(MAXC));

        // 6: start during SETTLE, then reset mid-run
        do_start(1'b0);
        vec_spaced(0, 0);
        do_vec(1'b0, 1'b1, 1'b0);
        do_start(1'b0);
        check("t6_restart_count", 32'(pass_count), 32'd0);
        check("t6_restart_cov", 32'(coverage), 32'd0);
        check("t6_restart_busy", 32'(busy), 32'd1);
        do_vec(1'b1, 1'b0, 1'b0);
        tick(1);
        do_reset();
        tick(2);

        // Randomized traffic against the model
        for (int it = 0; it < 500; it++) begin
            int r = int'($urandom_range(0, 99));
            if (r < 4) begin
                do_start(1'b0);
            end else if (r < 7) begin
                do_start(1'b1);
            end else if (r < 40) begin
                do_vec(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 5) == 0));
            end else if (r == 99) begin
                do_reset();
            end else begin
                tick(1);
            end
        end
        tick(S + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
